// File: rtl/ahbl_burst_master_if.sv
//------------------------------------------------------------------------------
// Module      : ahbl_burst_master_if
// Description : Client command port plus AHB-Lite manager bus, grouped for
//               ahbl_burst_master.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ahbl_burst_master_if #(
  parameter int AHB_AWIDTH = 32,
  parameter int AHB_DWIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [AHB_AWIDTH-1:0] cmd_addr;
  logic [1:0]            cmd_size;
  logic [1:0]            cmd_burst;
  logic [AHB_DWIDTH-1:0] wdata;
  logic                  wdata_ack;
  logic [AHB_DWIDTH-1:0] rdata;
  logic                  rdata_valid;
  logic                  done;
  logic                  err;

  logic [AHB_AWIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic                  HMASTLOCK;
  logic [AHB_DWIDTH-1:0] HWDATA;
  logic [AHB_DWIDTH-1:0] HRDATA;
  logic                  HREADY;
  logic [1:0]            HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_burst, wdata,
    input  HRDATA, HREADY, HRESP,
    output cmd_ready, wdata_ack, rdata, rdata_valid, done, err,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_burst, wdata,
    output HRDATA, HREADY, HRESP,
    input  cmd_ready, wdata_ack, rdata, rdata_valid, done, err,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HWDATA
  );
endinterface

`default_nettype wire

// File: rtl/ahbl_burst_master.sv
//------------------------------------------------------------------------------
// Module      : ahbl_burst_master
// Description : AHB-Lite initiator turning single client commands into
//               SINGLE/INCR4/INCR8/INCR16 pipelined read or write bursts.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ahbl_burst_master #(
  parameter int AHB_AWIDTH = 32,
  parameter int AHB_DWIDTH = 32
) (
  input  logic                HCLK,
  input  logic                HRESETN,
  ahbl_burst_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_XFER   = 3'd1,
    S_LAST   = 3'd2,
    S_CANCEL = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] c_HTRANS_SEQ    = 2'b11;
  localparam logic [1:0] c_HRESP_OKAY    = 2'b00;
  localparam logic [1:0] c_HRESP_ERROR   = 2'b01;

  state_t                r_state;
  logic [4:0]            r_beats_left;
  logic [2:0]            r_inc;
  logic [AHB_AWIDTH-1:0] r_haddr;
  logic [1:0]            r_htrans;
  logic                  r_hwrite;
  logic [2:0]            r_hsize;
  logic [2:0]            r_hburst;
  logic                  r_dphase;
  logic                  r_done;
  logic                  r_err;

  logic [1:0]            w_size_eff;
  logic [4:0]            w_beats;
  logic [2:0]            w_hburst;
  logic                  w_resp_ok;
  logic                  w_err_wait;
  logic                  w_err_end;

  assign w_size_eff = (bus.cmd_size == 2'b11) ? 2'b10 : bus.cmd_size;
  assign w_resp_ok  = (bus.HRESP == c_HRESP_OKAY);
  assign w_err_wait = r_dphase && !bus.HREADY && (bus.HRESP == c_HRESP_ERROR);
  assign w_err_end  = r_dphase &&  bus.HREADY && (bus.HRESP == c_HRESP_ERROR);

  always_comb begin
    w_beats  = 5'd1;
    w_hburst = 3'b000;
    case (bus.cmd_burst)
      2'b01:   begin w_beats = 5'd4;  w_hburst = 3'b011; end
      2'b10:   begin w_beats = 5'd8;  w_hburst = 3'b101; end
      2'b11:   begin w_beats = 5'd16; w_hburst = 3'b111; end
      default: begin w_beats = 5'd1;  w_hburst = 3'b000; end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      r_state      <= S_IDLE;
      r_beats_left <= 5'd0;
      r_inc        <= 3'd0;
      r_haddr      <= '0;
      r_htrans     <= c_HTRANS_IDLE;
      r_hwrite     <= 1'b0;
      r_hsize      <= 3'b000;
      r_hburst     <= 3'b000;
      r_dphase     <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_htrans     <= c_HTRANS_NONSEQ;
            r_haddr      <= bus.cmd_addr;
            r_hwrite     <= bus.cmd_write;
            r_hsize      <= {1'b0, w_size_eff};
            r_hburst     <= w_hburst;
            r_beats_left <= w_beats;
            r_inc        <= 3'd1 << w_size_eff;
            r_state      <= S_XFER;
          end
        end
        S_XFER, S_LAST: begin
          // First ERROR cycle: withdraw pending address, wait for second cycle
          if (w_err_wait) begin
            r_htrans <= c_HTRANS_IDLE;
            r_state  <= S_CANCEL;
          end else if (w_err_end) begin
            r_htrans <= c_HTRANS_IDLE;
            r_dphase <= 1'b0;
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_err    <= 1'b1;
          end else if (bus.HREADY) begin
            r_dphase <= r_htrans[1];
            if (r_htrans[1]) begin
              r_beats_left <= r_beats_left - 5'd1;
              if (r_beats_left == 5'd1) begin
                r_htrans <= c_HTRANS_IDLE;
                r_state  <= S_LAST;
              end else begin
                r_htrans <= c_HTRANS_SEQ;
                r_haddr  <= r_haddr + {{(AHB_AWIDTH-3){1'b0}}, r_inc};
              end
            end else if (r_state == S_LAST) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_CANCEL: begin
          if (bus.HREADY) begin
            r_dphase <= 1'b0;
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_err    <= 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = (r_state == S_IDLE);
  assign bus.HADDR       = r_haddr;
  assign bus.HTRANS      = r_htrans;
  assign bus.HWRITE      = r_hwrite;
  assign bus.HSIZE       = r_hsize;
  assign bus.HBURST      = r_hburst;
  assign bus.HMASTLOCK   = 1'b0;
  assign bus.HWDATA      = (r_dphase && r_hwrite) ? bus.wdata : {AHB_DWIDTH{1'b0}};
  assign bus.wdata_ack   = r_dphase &&  r_hwrite && bus.HREADY && w_resp_ok;
  assign bus.rdata       = bus.HRDATA;
  assign bus.rdata_valid = r_dphase && !r_hwrite && bus.HREADY && w_resp_ok;
  assign bus.done        = r_done;
  assign bus.err         = r_err;

endmodule

`default_nettype wire
